// File: rtl/switch_mcu_ex_sequencer_if.sv
// Decoder <-> execution sequencer bundle: instruction handshake, class
// decode, hold/flush controls and the per-class execution strobes.
interface switch_mcu_ex_sequencer_if;
    logic       in_dec_valid;
    logic       out_dec_ready;
    logic       in_type_u;
    logic       in_type_i;
    logic       in_type_r;
    logic       in_type_j;
    logic       in_hold;
    logic       in_flush_req;
    logic [3:0] out_cycle_cnt;
    logic       out_type_u_en;
    logic       out_type_i_en;
    logic       out_type_r_en;
    logic       out_type_j_en;
    logic       out_stall;
    logic       out_retire;
    logic       out_err;
    logic       out_busy;

    // Decoder / J-unit side
    modport master (
        output in_dec_valid, in_type_u, in_type_i, in_type_r, in_type_j,
               in_hold, in_flush_req,
        input  out_dec_ready, out_cycle_cnt, out_type_u_en, out_type_i_en,
               out_type_r_en, out_type_j_en, out_stall, out_retire,
               out_err, out_busy
    );

    // Sequencer side
    modport slave (
        input  in_dec_valid, in_type_u, in_type_i, in_type_r, in_type_j,
               in_hold, in_flush_req,
        output out_dec_ready, out_cycle_cnt, out_type_u_en, out_type_i_en,
               out_type_r_en, out_type_j_en, out_stall, out_retire,
               out_err, out_busy
    );
endinterface

// File: rtl/switch_mcu_ex_sequencer.sv
// Execution-stage sequencer: accepts one decoded instruction at a time,
// steps the shared cycle counter for its class, and inserts flush stall
// windows after PC overrides.
module switch_mcu_ex_sequencer #(
    parameter int unsigned CYC_U     = 2,
    parameter int unsigned CYC_I     = 3,
    parameter int unsigned CYC_R     = 3,
    parameter int unsigned CYC_J     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input logic                      in_clk,
    input logic                      in_rst,
    switch_mcu_ex_sequencer_if.slave sif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_FLUSH
    } state_t;

    localparam logic [3:0] LAST_U     = 4'(CYC_U - 1);
    localparam logic [3:0] LAST_I     = 4'(CYC_I - 1);
    localparam logic [3:0] LAST_R     = 4'(CYC_R - 1);
    localparam logic [3:0] LAST_J     = 4'(CYC_J - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cls_q, cls_d;      // one-hot {j, r, i, u}
    logic [3:0] cnt_q, cnt_d;
    logic       fp_q, fp_d;        // flush pending
    logic       retire_q, retire_d;
    logic       err_q, err_d;

    logic [3:0] in_cls;
    logic [3:0] last_idx;
    logic       is_last;
    logic       dec_ready;
    logic       xfer;
    logic       do_accept;

    // Class decode of the incoming instruction and last-cycle index of the current one
    always_comb begin
        in_cls = {sif.in_type_j, sif.in_type_r, sif.in_type_i, sif.in_type_u};
        case (cls_q)
            4'b0001: last_idx = LAST_U;
            4'b0010: last_idx = LAST_I;
            4'b0100: last_idx = LAST_R;
            4'b1000: last_idx = LAST_J;
            default: last_idx = '0;
        endcase
        is_last = (cnt_q == last_idx);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= ST_IDLE;
            cls_q    <= '0;
            cnt_q    <= '0;
            fp_q     <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            fp_q     <= fp_d;
            retire_q <= retire_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; a transfer seen in IDLE or on the final EXEC cycle
    // is classified once, after the case, through do_accept
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = cnt_q;
        fp_d      = fp_q;
        retire_d  = 1'b0;
        err_d     = 1'b0;
        do_accept = 1'b0;
        xfer      = sif.in_dec_valid & dec_ready;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                fp_d  = 1'b0;
                if (sif.in_flush_req) begin
                    state_d = ST_FLUSH;
                end else if (xfer) begin
                    do_accept = 1'b1;
                end
            end
            ST_EXEC: begin
                if (sif.in_flush_req) begin
                    fp_d = 1'b1;
                end
                if (!sif.in_hold) begin
                    if (!is_last) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        retire_d = 1'b1;
                        cnt_d    = '0;
                        if (fp_q || sif.in_flush_req) begin
                            state_d = ST_FLUSH;
                        end else if (xfer) begin
                            do_accept = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    fp_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                fp_d    = 1'b0;
            end
        endcase

        if (do_accept) begin
            cnt_d = '0;
            if ($onehot(in_cls)) begin
                state_d = ST_EXEC;
                cls_d   = in_cls;
            end else if (in_cls == '0) begin
                state_d  = ST_IDLE;
                retire_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end
        end
    end

    // Output decode from registers; ready alone looks at live hold/flush/reset
    always_comb begin
        dec_ready = 1'b0;
        if (!in_rst) begin
            case (state_q)
                ST_IDLE: dec_ready = !sif.in_flush_req;
                ST_EXEC: dec_ready = is_last && !sif.in_hold && !fp_q && !sif.in_flush_req;
                default: dec_ready = 1'b0;
            endcase
        end
        sif.out_dec_ready = dec_ready;
        sif.out_cycle_cnt = (state_q == ST_EXEC) ? cnt_q : '0;
        sif.out_type_u_en = (state_q == ST_EXEC) && cls_q[0];
        sif.out_type_i_en = (state_q == ST_EXEC) && cls_q[1];
        sif.out_type_r_en = (state_q == ST_EXEC) && cls_q[2];
        sif.out_type_j_en = (state_q == ST_EXEC) && cls_q[3];
        sif.out_stall     = (state_q == ST_FLUSH);
        sif.out_busy      = (state_q != ST_IDLE);
        sif.out_retire    = retire_q;
        sif.out_err       = err_q;
    end

endmodule

// File: tb/tb_switch_mcu_ex_sequencer.sv
// Directed bench for the execution sequencer: a cycle-by-cycle vector table
// plus a back-to-back throughput sequence.
module tb_switch_mcu_ex_sequencer;

    localparam int CU = 4'b0001;
    localparam int CI = 4'b0010;
    localparam int CR = 4'b0100;
    localparam int CJ = 4'b1000;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  cls;    // {j, r, i, u}
        logic        hold;
        logic        flush;
        logic [12:0] exp;    // {ready, cnt[3:0], en{j,r,i,u}, stall, retire, err, busy}
    } vec_t;

    logic in_clk;
    logic in_rst;
    switch_mcu_ex_sequencer_if sif();

    switch_mcu_ex_sequencer #(
        .CYC_U(2), .CYC_I(3), .CYC_R(3), .CYC_J(4), .FLUSH_CYC(2)
    ) dut (
        .in_clk(in_clk),
        .in_rst(in_rst),
        .sif   (sif)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic add(input int rst, input int v, input int cls, input int h, input int f,
                       input int rdy, input int cnt, input int en, input int st,
                       input int ret, input int err, input int busy);
        vec_t x;
        x.rst   = rst[0];
        x.valid = v[0];
        x.cls   = 4'(cls);
        x.hold  = h[0];
        x.flush = f[0];
        x.exp   = {rdy[0], 4'(cnt), 4'(en), st[0], ret[0], err[0], busy[0]};
        vecs.push_back(x);
    endtask

    task automatic drive(input logic rst, input logic v, input logic [3:0] cls,
                         input logic h, input logic f);
        in_rst           = rst;
        sif.in_dec_valid = v;
        sif.in_type_u    = cls[0];
        sif.in_type_i    = cls[1];
        sif.in_type_r    = cls[2];
        sif.in_type_j    = cls[3];
        sif.in_hold      = h;
        sif.in_flush_req = f;
    endtask

    function automatic logic [12:0] observed();
        return {sif.out_dec_ready, sif.out_cycle_cnt,
                sif.out_type_j_en, sif.out_type_r_en, sif.out_type_i_en, sif.out_type_u_en,
                sif.out_stall, sif.out_retire, sif.out_err, sif.out_busy};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        int xfers;
        int en_cyc;
        int rets;
        int first;
        int last;

        // rst v cls h f | rdy cnt en st ret err busy
        add(1,0,0,0,0,   0,0,0, 0,0,0,0);   // reset state
        add(0,0,0,0,0,   1,0,0, 0,0,0,0);   // first IDLE after release
        add(0,1,CR,0,0,  1,0,0, 0,0,0,0);   // R transfer
        add(0,0,0,0,0,   0,0,CR,0,0,0,1);
        add(0,0,0,0,0,   0,1,CR,0,0,0,1);
        add(0,0,0,0,0,   1,2,CR,0,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,1,0,0);   // R retire
        add(0,1,CU,0,0,  1,0,0, 0,0,0,0);   // U transfer
        add(0,1,CI,0,0,  0,0,CU,0,0,0,1);   // I held on valid
        add(0,1,CI,0,0,  1,1,CU,0,0,0,1);   // I accepted on U last cycle
        add(0,0,0,0,0,   0,0,CI,0,1,0,1);   // no bubble, U retire
        add(0,0,0,0,0,   0,1,CI,0,0,0,1);
        add(0,0,0,0,0,   1,2,CI,0,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,1,0,0);
        add(0,1,CJ,0,0,  1,0,0, 0,0,0,0);   // J with hold
        add(0,0,0,0,0,   0,0,CJ,0,0,0,1);
        add(0,0,0,1,0,   0,1,CJ,0,0,0,1);
        add(0,0,0,1,0,   0,1,CJ,0,0,0,1);
        add(0,0,0,0,0,   0,1,CJ,0,0,0,1);
        add(0,0,0,0,0,   0,2,CJ,0,0,0,1);
        add(0,0,0,0,0,   1,3,CJ,0,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,1,0,0);
        add(0,1,CJ,0,0,  1,0,0, 0,0,0,0);   // J with flush at cnt 2
        add(0,1,CI,0,0,  0,0,CJ,0,0,0,1);
        add(0,1,CI,0,0,  0,1,CJ,0,0,0,1);
        add(0,1,CI,0,1,  0,2,CJ,0,0,0,1);
        add(0,1,CI,0,0,  0,3,CJ,0,0,0,1);   // pending flush blocks ready
        add(0,1,CI,0,0,  0,0,0, 1,1,0,1);
        add(0,1,CI,0,0,  0,0,0, 1,0,0,1);
        add(0,1,CI,0,0,  1,0,0, 0,0,0,0);   // accept after flush
        add(0,0,0,0,0,   0,0,CI,0,0,0,1);
        add(0,0,0,0,0,   0,1,CI,0,0,0,1);
        add(0,0,0,0,1,   0,2,CI,0,0,0,1);   // flush on last cycle
        add(0,0,0,0,1,   0,0,0, 1,1,0,1);   // flush req ignored in FLUSH
        add(0,0,0,0,0,   0,0,0, 1,0,0,1);
        add(0,1,CI|CR,0,0, 1,0,0,0,0,0,0);  // multi-hot
        add(0,0,0,0,0,   1,0,0, 0,0,1,0);
        add(0,1,0,0,0,   1,0,0, 0,0,0,0);   // NOP
        add(0,0,0,0,0,   1,0,0, 0,1,0,0);
        add(0,1,CU,0,1,  0,0,0, 0,0,0,0);   // flush beats transfer in IDLE
        add(0,0,0,0,0,   0,0,0, 1,0,0,1);
        add(0,0,0,0,0,   0,0,0, 1,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,0,0,0);
        add(0,1,CR,0,0,  1,0,0, 0,0,0,0);   // reset mid-EXEC
        add(0,0,0,0,0,   0,0,CR,0,0,0,1);
        add(1,0,0,0,0,   0,1,CR,0,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,0,0,0);   // no retire after reset
        add(0,1,CU,0,0,  1,0,0, 0,0,0,0);   // hold beats flush exit
        add(0,0,0,0,0,   0,0,CU,0,0,0,1);
        add(0,0,0,1,1,   0,1,CU,0,0,0,1);
        add(0,0,0,0,0,   0,1,CU,0,0,0,1);
        add(0,0,0,1,0,   0,0,0, 1,1,0,1);   // hold ignored in FLUSH
        add(0,0,0,1,0,   0,0,0, 1,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,0,0,0);
        add(0,0,0,0,1,   0,0,0, 0,0,0,0);   // reset mid-FLUSH
        add(1,0,0,0,0,   0,0,0, 1,0,0,1);
        add(0,0,0,0,0,   1,0,0, 0,0,0,0);

        drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge in_clk);

        foreach (vecs[k]) begin
            @(negedge in_clk);
            drive(vecs[k].rst, vecs[k].valid, vecs[k].cls, vecs[k].hold, vecs[k].flush);
            #1;
            check($sformatf("vec%0d", k), int'(observed()), int'(vecs[k].exp));
        end

        // Three back-to-back R instructions with valid held continuously
        xfers  = 0;
        en_cyc = 0;
        rets   = 0;
        first  = -1;
        last   = -1;
        for (int c = 0; c < 40 && rets < 3; c++) begin
            @(negedge in_clk);
            if (xfers == 3) drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
            else            drive(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
            #1;
            if (sif.out_type_r_en) begin
                en_cyc++;
                if (first < 0) first = c;
                last = c;
            end
            if (sif.out_retire) rets++;
            if (sif.out_dec_ready && sif.in_dec_valid) xfers++;
        end
        check("b2b_retires", rets, 3);
        check("b2b_transfers", xfers, 3);
        check("b2b_enable_cycles", en_cyc, 9);
        check("b2b_contiguous", last - first + 1, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
